// File: rtl/ext_bridge_arbiter.sv
// ext_bridge_arbiter
//   Two-port arbiter and sequencer for the 16-bit external Avalon bridge
//   slave of mp3player_soc. Port 0 is the audio sample fetcher and port 1 is
//   the UI/control logic. Only one read or write is in flight at a time. Each
//   transfer runs until the bridge acknowledges it. Read data then goes back
//   to the port that won the grant.
//
//   Parameters
//     ADDR_W          bridge word address width
//     DATA_W          bridge data width
//     TIMEOUT_CYCLES  strobe cycles without acknowledge before abort
//                     (only used when EXT_BRIDGE_ARB_TIMEOUT_EN is defined)
//
//   Ports
//     clk_clk, reset_reset_n          clock, asynchronous active-low reset
//     pN_req/we/addr/be/wdata         requester N (N = 0,1) transfer request
//     pN_done/rdata/err               one-cycle completion pulse with result
//     bridge_*                        Avalon bridge master side
//     busy                            arbiter not idle
//
//   Optional feature
//     EXT_BRIDGE_ARB_TIMEOUT_EN: abort a transfer after TIMEOUT_CYCLES strobe
//     cycles without acknowledge. The port then sees done with err set.
//     Without the macro, BUSY waits for the acknowledge indefinitely and
//     pN_err is tied low.
module ext_bridge_arbiter #(
  parameter int ADDR_W         = 26,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [1:0]        p0_be,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [1:0]        p1_be,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,

  output logic [ADDR_W-1:0] bridge_address,
  output logic [1:0]        bridge_byte_enable,
  output logic              bridge_read,
  output logic              bridge_write,
  output logic [DATA_W-1:0] bridge_write_data,
  input  logic              bridge_acknowledge,
  input  logic [DATA_W-1:0] bridge_read_data,

  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_d;
  logic              last_grant;    // port of the current / most recent grant
  logic              grant_req;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              finish;        // transfer ends this cycle (ack or abort)
  logic [DATA_W-1:0] finish_rdata;
  logic              timeout_hit;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_req  = p0_req | p1_req;
    grant_port = p1_req;
    // With both ports requesting, give the grant to the port that did not
    // win last time. This makes continuous requests strictly alternate.
    if (p0_req && p1_req) grant_port = ~last_grant;

    sel_we    = grant_port ? p1_we    : p0_we;
    sel_addr  = grant_port ? p1_addr  : p0_addr;
    sel_be    = grant_port ? p1_be    : p0_be;
    sel_wdata = grant_port ? p1_wdata : p0_wdata;

    finish       = (state == BUSY) && (bridge_acknowledge || timeout_hit);
    // Writes and aborted transfers return zero. Only an acknowledged read
    // returns bridge data. Acknowledge wins over a coincident timeout.
    finish_rdata = (bridge_acknowledge && bridge_read) ? bridge_read_data : '0;

    state_d = state;
    unique case (state)
      IDLE:    if (grant_req) state_d = BUSY;
      BUSY:    if (finish)    state_d = DONE;
      DONE:    state_d = IDLE;  // requests ignored for this one cycle
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register has an asynchronous reset value so strobes drop the moment
  // reset_reset_n falls.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      last_grant         <= 1'b1;
      busy               <= 1'b0;
      bridge_address     <= '0;
      bridge_byte_enable <= '0;
      bridge_read        <= 1'b0;
      bridge_write       <= 1'b0;
      bridge_write_data  <= '0;
      p0_done            <= 1'b0;
      p0_rdata           <= '0;
      p1_done            <= 1'b0;
      p1_rdata           <= '0;
    end else begin
      busy     <= (state_d != IDLE);
      // The completion outputs are single-cycle pulses.
      p0_done  <= 1'b0;
      p0_rdata <= '0;
      p1_done  <= 1'b0;
      p1_rdata <= '0;

      if (state == IDLE && grant_req) begin
        last_grant         <= grant_port;
        bridge_address     <= sel_addr;
        bridge_byte_enable <= sel_be;
        bridge_write_data  <= sel_wdata;
        bridge_read        <= ~sel_we;
        bridge_write       <= sel_we;
      end

      if (finish) begin
        bridge_read  <= 1'b0;
        bridge_write <= 1'b0;
        if (last_grant) begin
          p1_done  <= 1'b1;
          p1_rdata <= finish_rdata;
        end else begin
          p0_done  <= 1'b1;
          p0_rdata <= finish_rdata;
        end
      end
    end
  end

`ifdef EXT_BRIDGE_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timeout_cnt;

  // The count equals the number of strobe cycles already spent without
  // acknowledge. The last allowed cycle is therefore TIMEOUT_LAST.
  assign timeout_hit = (state == BUSY) && !bridge_acknowledge &&
                       (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      timeout_cnt <= '0;
      p0_err      <= 1'b0;
      p1_err      <= 1'b0;
    end else begin
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      // Clearing in IDLE leaves the counter at zero on entry to BUSY.
      if (state == IDLE) begin
        timeout_cnt <= '0;
      end else if (state == BUSY && !bridge_acknowledge) begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
      if (timeout_hit) begin
        if (last_grant) p1_err <= 1'b1;
        else            p0_err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  // Without the timeout feature, the limit parameter has no effect.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign p0_err             = 1'b0;
  assign p1_err             = 1'b0;
`endif

endmodule

// File: tb/tb_ext_bridge_arbiter.sv
// tb_ext_bridge_arbiter
//   Directed bench for ext_bridge_arbiter. A bridge responder acknowledges
//   each strobe after a programmable number of strobe cycles and logs every
//   transfer. A completion monitor pops the expected result for each done
//   pulse from a scoreboard queue that is filled when stimulus is driven.
//   Build with EXT_BRIDGE_ARB_TIMEOUT_EN to run the abort cases
//   (TIMEOUT_CYCLES = 16).
`timescale 1ns/1ps
module tb_ext_bridge_arbiter;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;
`ifdef EXT_BRIDGE_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  typedef struct {
    bit              port;
    logic [DATA_W-1:0] rdata;
    bit              err;
  } exp_t;

  typedef struct {
    int                c;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } strobe_t;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [1:0]        p0_be, p1_be;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_done, p0_err, p1_done, p1_err;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] bridge_address;
  logic [1:0]        bridge_byte_enable;
  logic              bridge_read, bridge_write;
  logic [DATA_W-1:0] bridge_write_data;
  logic              bridge_acknowledge = 1'b0;
  logic [DATA_W-1:0] bridge_read_data   = 16'h5A5A;
  logic              busy;

  int      n_tests  = 0;
  int      n_fail   = 0;
  int      cyc      = 0;
  int      ack_lat  = 1;       // strobe cycle that carries ack, 0 = never
  logic [DATA_W-1:0] rd_value = '0;
  exp_t    sb_q[$];
  strobe_t st_q[$];
  int      done_cyc_q[$];
  bit      in_strobe = 1'b0;
  int      s_len     = 0;
  int      last_len  = 0;
  int      rd_cnt    = 0;
  strobe_t cur;

  ext_bridge_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk_clk            (clk_clk),
    .reset_reset_n      (reset_reset_n),
    .p0_req             (p0_req),
    .p0_we              (p0_we),
    .p0_addr            (p0_addr),
    .p0_be              (p0_be),
    .p0_wdata           (p0_wdata),
    .p0_done            (p0_done),
    .p0_rdata           (p0_rdata),
    .p0_err             (p0_err),
    .p1_req             (p1_req),
    .p1_we              (p1_we),
    .p1_addr            (p1_addr),
    .p1_be              (p1_be),
    .p1_wdata           (p1_wdata),
    .p1_done            (p1_done),
    .p1_rdata           (p1_rdata),
    .p1_err             (p1_err),
    .bridge_address     (bridge_address),
    .bridge_byte_enable (bridge_byte_enable),
    .bridge_read        (bridge_read),
    .bridge_write       (bridge_write),
    .bridge_write_data  (bridge_write_data),
    .bridge_acknowledge (bridge_acknowledge),
    .bridge_read_data   (bridge_read_data),
    .busy               (busy)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit port, input logic [DATA_W-1:0] rdata, input bit err);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  // Returns at the falling edge where a done pulse is seen.
  task automatic wait_done(input string tag, input int budget, output int dcyc);
    bit seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_clk);
      if (p0_done || p1_done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    check({tag, "_wait_done"}, 32'(seen), 32'd1);
  endtask

  // Bridge responder: logs each strobe, checks hold/exclusivity, acks.
  always @(negedge clk_clk) begin
    if (bridge_read) rd_cnt++;
    if (bridge_read || bridge_write) begin
      if (!in_strobe) begin
        in_strobe = 1'b1;
        s_len     = 0;
        cur = '{cyc, bridge_address, bridge_byte_enable, bridge_write_data,
                bridge_read, bridge_write};
        st_q.push_back(cur);
      end else begin
        check("strobe_hold_addr", 32'(bridge_address), 32'(cur.addr));
        check("strobe_hold_ctl",
              32'({bridge_read, bridge_write, bridge_byte_enable, bridge_write_data}),
              32'({cur.rd, cur.wr, cur.be, cur.wdata}));
      end
      check("strobe_overlap", 32'(bridge_read & bridge_write), 32'd0);
      s_len++;
      bridge_acknowledge = (ack_lat != 0) && (s_len == ack_lat);
      bridge_read_data   = bridge_acknowledge ? rd_value : 16'h5A5A;
    end else begin
      if (in_strobe) last_len = s_len;
      in_strobe          = 1'b0;
      bridge_acknowledge = 1'b0;
      bridge_read_data   = 16'h5A5A;
    end
  end

  // Completion monitor / scoreboard.
  always @(negedge clk_clk) begin
    exp_t       e;
    logic [1:0] exp_mask;
    if (p0_done || p1_done) begin
      e = '{1'b0, '0, 1'b0};
      exp_mask = 2'b00;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_mask = e.port ? 2'b10 : 2'b01;
      end
      check("done_port", 32'({p1_done, p0_done}), 32'(exp_mask));
      check("done_rdata", 32'(e.port ? p1_rdata : p0_rdata), 32'(e.rdata));
      check("done_err", 32'(e.port ? p1_err : p0_err), 32'(e.err));
      check("loser_quiet", 32'(e.port ? {p0_err, p0_rdata} : {p1_err, p1_rdata}), 32'd0);
      done_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, d2, base, db, rb;
    reset_reset_n = 1'b1;
    {p0_req, p0_we, p0_addr, p0_be, p0_wdata} = '0;
    {p1_req, p1_we, p1_addr, p1_be, p1_wdata} = '0;
    #2 reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);

    // Reset state
    check("reset_ctl", 32'({bridge_read, bridge_write, busy, p0_done, p1_done, p0_err, p1_err}), 32'd0);
    check("reset_addr", 32'(bridge_address), 32'd0);
    check("reset_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // Port 0 read, ack in third strobe cycle; inputs scrambled after capture
    ack_lat = 3; rd_value = 16'hBEEF; base = st_q.size();
    p0_addr = 26'h0000100; p0_we = 1'b0; p0_be = 2'b11; p0_wdata = 16'h1111; p0_req = 1'b1;
    push_exp(1'b0, 16'hBEEF, 1'b0);
    d0 = cyc;
    repeat (2) @(negedge clk_clk);
    p0_addr = 26'h3FFFFFF; p0_we = 1'b1; p0_be = 2'b00; p0_wdata = 16'hFFFF;
    wait_done("t1", 20, d1);
    p0_req = 1'b0;
    @(negedge clk_clk);
    check("t1_strobe_len", 32'(last_len), 32'd3);
    check("t1_addr", 32'(st_q[base].addr), 32'h0000100);
    check("t1_is_read", 32'({st_q[base].rd, st_q[base].wr}), 32'b10);
    check("t1_strobe_latency", 32'(st_q[base].c - d0), 32'd1);
    check("t1_done_latency", 32'(d1 - d0), 32'd4);

    // Port 1 write, ack in first strobe cycle
    ack_lat = 1; rd_value = 16'hDEAD; base = st_q.size(); rb = rd_cnt;
    p1_addr = 26'h2000004; p1_we = 1'b1; p1_be = 2'b01; p1_wdata = 16'h00A5; p1_req = 1'b1;
    push_exp(1'b1, 16'h0000, 1'b0);
    wait_done("t2", 20, d1);
    p1_req = 1'b0;
    @(negedge clk_clk);
    check("t2_addr", 32'(st_q[base].addr), 32'h2000004);
    check("t2_be", 32'(st_q[base].be), 32'b01);
    check("t2_wdata", 32'(st_q[base].wdata), 32'h00A5);
    check("t2_is_write", 32'({st_q[base].rd, st_q[base].wr}), 32'b01);
    check("t2_strobe_len", 32'(last_len), 32'd1);
    check("t2_no_read", 32'(rd_cnt - rb), 32'd0);

    // Both ports requesting from reset: strict alternation 0,1,0,1
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    ack_lat = 1; rd_value = 16'h1234; base = st_q.size(); db = done_cyc_q.size();
    p0_addr = 26'h10; p0_we = 1'b0; p0_be = 2'b11;
    p1_addr = 26'h20; p1_we = 1'b1; p1_be = 2'b11; p1_wdata = 16'h5555;
    push_exp(1'b0, 16'h1234, 1'b0);
    push_exp(1'b1, 16'h0000, 1'b0);
    push_exp(1'b0, 16'h1234, 1'b0);
    push_exp(1'b1, 16'h0000, 1'b0);
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (4) wait_done("t3", 20, d1);
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk_clk);
    check("t3_count", 32'(st_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t3_order", 32'(st_q[base+i].addr), (i % 2 == 1) ? 32'h20 : 32'h10);
    for (int i = 1; i < 4; i++)
      check("t3_spacing", 32'(done_cyc_q[db+i] - done_cyc_q[db+i-1]), 32'd3);

    // Back-to-back: port 0 holds req through DONE with a new address
    ack_lat = 1; rd_value = 16'h0F0F; base = st_q.size();
    p0_addr = 26'h40; p0_we = 1'b0; p0_req = 1'b1;
    push_exp(1'b0, 16'h0F0F, 1'b0);
    push_exp(1'b0, 16'h0F0F, 1'b0);
    wait_done("t4a", 20, d1);
    p0_addr = 26'h44;
    wait_done("t4b", 20, d2);
    p0_req = 1'b0;
    @(negedge clk_clk);
    check("t4_count", 32'(st_q.size() - base), 32'd2);
    check("t4_gap", 32'(st_q[base+1].c - d1), 32'd2);
    check("t4_addr2", 32'(st_q[base+1].addr), 32'h44);

`ifdef EXT_BRIDGE_ARB_TIMEOUT_EN
    // No ack: abort after 16 strobe cycles with err
    ack_lat = 0; rd_value = 16'hFFFF;
    p0_addr = 26'h50; p0_we = 1'b0; p0_req = 1'b1;
    push_exp(1'b0, 16'h0000, 1'b1);
    wait_done("t5a", 40, d1);
    p0_req = 1'b0;
    @(negedge clk_clk);
    check("t5a_strobe_len", 32'(last_len), 32'd16);
    // Ack in the 16th cycle wins over the timeout
    ack_lat = 16;
    p0_req = 1'b1;
    push_exp(1'b0, 16'hFFFF, 1'b0);
    wait_done("t5b", 40, d1);
    p0_req = 1'b0;
    @(negedge clk_clk);
    check("t5b_strobe_len", 32'(last_len), 32'd16);
`endif

    // Reset mid-BUSY: strobes drop at once, no done for the lost transfer
    ack_lat = 0;
    p1_addr = 26'h77; p1_we = 1'b0; p1_req = 1'b1;
    repeat (3) @(negedge clk_clk);
    check("t6_strobe_before", 32'(bridge_read), 32'd1);
    reset_reset_n = 1'b0;
    #1;
    check("t6_strobe_async", 32'({bridge_read, bridge_write, busy}), 32'd0);
    p1_req = 1'b0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    ack_lat = 1; rd_value = 16'hC0DE; base = st_q.size();
    p0_addr = 26'h80; p0_we = 1'b0;
    p1_addr = 26'h90; p1_we = 1'b1; p1_wdata = 16'h0042;
    push_exp(1'b0, 16'hC0DE, 1'b0);
    push_exp(1'b1, 16'h0000, 1'b0);
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (2) wait_done("t6", 20, d1);
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk_clk);
    check("t6_first_grant", 32'(st_q[base].addr), 32'h80);

    repeat (3) @(negedge clk_clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
